// File: rtl/vector_response_checker.sv
// Scores (pattern, response) records against a loaded golden truth table and reports
// pass/fail, the mismatch count, the first failing pattern and duplicate arrivals.
module vector_response_checker #(
    parameter int unsigned IN_W = 7
) (
    input  logic            CK,
    input  logic            reset,
    input  logic            start,
    input  logic            gold_valid,
    input  logic            gold_bit,
    output logic            gold_ready,
    input  logic            rec_valid,
    input  logic [IN_W-1:0] rec_pattern,
    input  logic            rec_out,
    output logic            rec_ready,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [IN_W:0]   mismatch_count,
    output logic            first_mismatch_vld,
    output logic [IN_W-1:0] first_mismatch_idx,
    output logic            dup_err
);

    localparam int unsigned   DEPTH   = 2 ** IN_W;
    localparam logic [IN_W:0] CntOne  = {{IN_W{1'b0}}, 1'b1};
    localparam logic [IN_W:0] LastCnt = {1'b0, {IN_W{1'b1}}};

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [IN_W:0]     gold_idx_q, gold_idx_d;
    logic [DEPTH-1:0]  seen_q, seen_d;
    logic [IN_W:0]     seen_cnt_q, seen_cnt_d;
    logic [IN_W:0]     mismatch_count_q, mismatch_count_d;
    logic              first_vld_q, first_vld_d;
    logic [IN_W-1:0]   first_idx_q, first_idx_d;
    logic              dup_err_q, dup_err_d;
    logic              pass_q, pass_d;
    logic [DEPTH-1:0]  gold_mem_q;
    logic              gold_we;
    logic              clear_results;

    always_comb begin
        state_d          = state_q;
        gold_idx_d       = gold_idx_q;
        seen_d           = seen_q;
        seen_cnt_d       = seen_cnt_q;
        mismatch_count_d = mismatch_count_q;
        first_vld_d      = first_vld_q;
        first_idx_d      = first_idx_q;
        dup_err_d        = dup_err_q;
        pass_d           = pass_q;
        gold_we          = 1'b0;
        clear_results    = 1'b0;

        unique case (state_q)
            StIdle: begin
                clear_results = 1'b1;
                if (start) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (gold_valid) begin
                    gold_we    = 1'b1;
                    gold_idx_d = gold_idx_q + CntOne;
                    if (gold_idx_q == LastCnt) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (rec_valid) begin
                    if (seen_q[rec_pattern]) begin
                        // Repeated patterns are flagged but never rescored.
                        dup_err_d = 1'b1;
                    end else begin
                        seen_d[rec_pattern] = 1'b1;
                        seen_cnt_d          = seen_cnt_q + CntOne;
                        if (rec_out != gold_mem_q[rec_pattern]) begin
                            mismatch_count_d = mismatch_count_q + CntOne;
                            if (!first_vld_q) begin
                                first_vld_d = 1'b1;
                                first_idx_d = rec_pattern;
                            end
                        end
                        if (seen_cnt_q == LastCnt) begin
                            state_d = StDone;
                            pass_d  = (mismatch_count_d == '0) && !dup_err_q;
                        end
                    end
                end
            end
            StDone: begin
                if (start) begin
                    clear_results = 1'b1;
                    state_d       = StLoad;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (clear_results) begin
            gold_idx_d       = '0;
            seen_d           = '0;
            seen_cnt_d       = '0;
            mismatch_count_d = '0;
            first_vld_d      = 1'b0;
            first_idx_d      = '0;
            dup_err_d        = 1'b0;
            pass_d           = 1'b0;
        end
    end

    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            state_q          <= StIdle;
            gold_idx_q       <= '0;
            seen_q           <= '0;
            seen_cnt_q       <= '0;
            mismatch_count_q <= '0;
            first_vld_q      <= 1'b0;
            first_idx_q      <= '0;
            dup_err_q        <= 1'b0;
            pass_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            gold_idx_q       <= gold_idx_d;
            seen_q           <= seen_d;
            seen_cnt_q       <= seen_cnt_d;
            mismatch_count_q <= mismatch_count_d;
            first_vld_q      <= first_vld_d;
            first_idx_q      <= first_idx_d;
            dup_err_q        <= dup_err_d;
            pass_q           <= pass_d;
        end
    end

    // Golden table needs no reset: every run reloads all DEPTH entries before RUN.
    always_ff @(posedge CK) begin
        if (gold_we) begin
            gold_mem_q[gold_idx_q[IN_W-1:0]] <= gold_bit;
        end
    end

    assign gold_ready         = (state_q == StLoad);
    assign rec_ready          = (state_q == StRun);
    assign busy               = (state_q == StLoad) || (state_q == StRun);
    assign done               = (state_q == StDone);
    assign pass               = pass_q;
    assign mismatch_count     = mismatch_count_q;
    assign first_mismatch_vld = first_vld_q;
    assign first_mismatch_idx = first_idx_q;
    assign dup_err            = dup_err_q;

endmodule

// File: tb/tb_vector_response_checker.sv
// Bench for vector_response_checker: directed vector table, randomized runs scored by a
// record-list reference model, and hand-written reset/restart sequences.
module tb_vector_response_checker;

    localparam int IN_W  = 7;
    localparam int DEPTH = 128;

    logic            CK = 1'b0;
    logic            reset;
    logic            start;
    logic            gold_valid;
    logic            gold_bit;
    logic            gold_ready;
    logic            rec_valid;
    logic [IN_W-1:0] rec_pattern;
    logic            rec_out;
    logic            rec_ready;
    logic            busy;
    logic            done;
    logic            pass;
    logic [IN_W:0]   mismatch_count;
    logic            first_mismatch_vld;
    logic [IN_W-1:0] first_mismatch_idx;
    logic            dup_err;

    vector_response_checker #(.IN_W(IN_W)) dut (
        .CK                 (CK),
        .reset              (reset),
        .start              (start),
        .gold_valid         (gold_valid),
        .gold_bit           (gold_bit),
        .gold_ready         (gold_ready),
        .rec_valid          (rec_valid),
        .rec_pattern        (rec_pattern),
        .rec_out            (rec_out),
        .rec_ready          (rec_ready),
        .busy               (busy),
        .done               (done),
        .pass               (pass),
        .mismatch_count     (mismatch_count),
        .first_mismatch_vld (first_mismatch_vld),
        .first_mismatch_idx (first_mismatch_idx),
        .dup_err            (dup_err)
    );

    always #5 CK = ~CK;

    int errors = 0;
    int checks = 0;

    bit gold_tb[DEPTH];
    int rec_pat[$];
    bit rec_bit[$];

    typedef struct {
        int gold_kind;   // 0 parity, 1 all ones
        int order;       // 0 ascending, 1 descending
        int flip_a;
        int flip_b;
        int dup_pat;
        int gaps;        // 0 full rate, 1 valid every other cycle
        int exp_mm;
        int exp_vld;
        int exp_first;
        int exp_dup;
        int exp_pass;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_gold(input int kind);
        for (int i = 0; i < DEPTH; i++) begin
            case (kind)
                0:       gold_tb[i] = bit'($countones(i) & 1);
                1:       gold_tb[i] = 1'b1;
                default: gold_tb[i] = bit'($urandom_range(0, 1));
            endcase
        end
    endtask

    // order 2 = random permutation; rnd adds random flips and duplicates.
    task automatic build(input int order, input int fa, input int fb, input int dp,
                         input bit rnd);
        int perm[DEPTH];
        rec_pat.delete();
        rec_bit.delete();
        for (int i = 0; i < DEPTH; i++) perm[i] = (order == 1) ? DEPTH - 1 - i : i;
        if (order == 2) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                int j = $urandom_range(0, i);
                int t = perm[i];
                perm[i] = perm[j];
                perm[j] = t;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            int p  = perm[i];
            bit fl = (p == fa) || (p == fb) || (rnd && $urandom_range(0, 15) == 0);
            rec_pat.push_back(p);
            rec_bit.push_back(gold_tb[p] ^ fl);
            if (i != DEPTH - 1 && (p == dp || (rnd && $urandom_range(0, 39) == 0))) begin
                rec_pat.push_back(p);
                rec_bit.push_back(!gold_tb[p]);
            end
        end
    endtask

    // Reference: walk the record list; first arrival of a pattern is scored, repeats flag dup.
    task automatic model(output int mm, output int vld, output int first, output int dup,
                         output int ps);
        bit seen[DEPTH];
        mm = 0; vld = 0; first = 0; dup = 0;
        for (int i = 0; i < DEPTH; i++) seen[i] = 1'b0;
        foreach (rec_pat[i]) begin
            if (seen[rec_pat[i]]) begin
                dup = 1;
            end else begin
                seen[rec_pat[i]] = 1'b1;
                if (rec_bit[i] != gold_tb[rec_pat[i]]) begin
                    if (mm == 0) begin
                        first = rec_pat[i];
                        vld   = 1;
                    end
                    mm++;
                end
            end
        end
        ps = (mm == 0 && dup == 0) ? 1 : 0;
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
        check({tag, " gold_ready after start"}, int'(gold_ready), 1);
        check({tag, " cleared after start"},
              int'({done, pass, rec_ready, mismatch_count, first_mismatch_vld,
                    first_mismatch_idx, dup_err}), 0);
    endtask

    task automatic do_load(input string tag, input bit gaps, input bit junk,
                           input int start_mid);
        int n = 0;
        int guard = 0;
        while (n < DEPTH && guard < 4000) begin
            bit v = gaps ? bit'($urandom_range(0, 1)) : 1'b1;
            guard++;
            gold_valid  = v;
            gold_bit    = gold_tb[n];
            start       = (n == start_mid) && v;
            rec_valid   = junk ? bit'($urandom_range(0, 1)) : 1'b0;
            rec_pattern = IN_W'($urandom);
            rec_out     = bit'($urandom_range(0, 1));
            if (v && n == DEPTH - 1)
                check({tag, " rec_ready before last gold"}, int'(rec_ready), 0);
            @(negedge CK);
            if (v) n++;
        end
        gold_valid = 1'b0;
        start      = 1'b0;
        rec_valid  = 1'b0;
        if (n < DEPTH) check({tag, " load cycle budget"}, n, DEPTH);
        check({tag, " rec_ready after load"}, int'({rec_ready, gold_ready, busy}), 3'b101);
    endtask

    // gaps: 0 full rate, 1 idle cycle after each record, 2 random idles.
    task automatic do_records(input string tag, input int gaps, input bit junk, input int limit);
        int n = (limit < rec_pat.size()) ? limit : rec_pat.size();
        for (int i = 0; i < n; i++) begin
            rec_valid   = 1'b1;
            rec_pattern = IN_W'(rec_pat[i]);
            rec_out     = rec_bit[i];
            gold_valid  = junk ? bit'($urandom_range(0, 1)) : 1'b0;
            if (i == rec_pat.size() - 1) check({tag, " done before last rec"}, int'(done), 0);
            @(negedge CK);
            rec_valid = 1'b0;
            if (i == rec_pat.size() - 1) begin
                check({tag, " done after last rec"}, int'({done, rec_ready, busy}), 3'b100);
            end else if (gaps == 1 || (gaps == 2 && $urandom_range(0, 2) == 0)) begin
                @(negedge CK);
            end
        end
        gold_valid = 1'b0;
    endtask

    task automatic check_results(input string tag, input int mm, input int vld, input int first,
                                 input int dup, input int ps);
        check({tag, " pass"}, int'(pass), ps);
        check({tag, " mismatch_count"}, int'(mismatch_count), mm);
        check({tag, " first_mismatch_vld"}, int'(first_mismatch_vld), vld);
        check({tag, " first_mismatch_idx"}, int'(first_mismatch_idx), first);
        check({tag, " dup_err"}, int'(dup_err), dup);
    endtask

    initial begin
        int mm, vld, first, dup, ps;

        vecs[0] = '{0, 0, -1, -1, -1, 0, 0, 0, 0, 0, 1};
        vecs[1] = '{0, 1, 'h2A, 'h05, -1, 0, 2, 1, 'h2A, 0, 0};
        vecs[2] = '{0, 0, -1, -1, 'h10, 1, 0, 0, 0, 1, 0};
        vecs[3] = '{1, 1, 'h7F, -1, -1, 1, 1, 1, 'h7F, 0, 0};
        vecs[4] = '{1, 0, 'h00, 'h33, 'h10, 0, 2, 1, 'h00, 1, 0};

        reset       = 1'b1;
        start       = 1'b0;
        gold_valid  = 1'b0;
        gold_bit    = 1'b0;
        rec_valid   = 1'b0;
        rec_pattern = '0;
        rec_out     = 1'b0;
        repeat (2) @(negedge CK);
        check("reset outputs",
              int'({gold_ready, rec_ready, busy, done, pass, mismatch_count,
                    first_mismatch_vld, first_mismatch_idx, dup_err}), 0);
        reset = 1'b0;

        // Stray valids in IDLE must do nothing.
        rec_valid  = 1'b1;
        gold_valid = 1'b1;
        repeat (3) @(negedge CK);
        rec_valid  = 1'b0;
        gold_valid = 1'b0;
        check("idle ignores valids", int'({busy, done, mismatch_count, dup_err}), 0);

        foreach (vecs[v]) begin
            string tag = $sformatf("vec%0d", v);
            set_gold(vecs[v].gold_kind);
            build(vecs[v].order, vecs[v].flip_a, vecs[v].flip_b, vecs[v].dup_pat, 1'b0);
            do_start(tag);
            do_load(tag, 1'b0, 1'b0, -1);
            do_records(tag, vecs[v].gaps, 1'b0, 1000);
            check_results(tag, vecs[v].exp_mm, vecs[v].exp_vld, vecs[v].exp_first,
                          vecs[v].exp_dup, vecs[v].exp_pass);
        end

        // Results hold in DONE despite stray traffic.
        for (int i = 0; i < 6; i++) begin
            rec_valid   = 1'b1;
            rec_pattern = IN_W'(i);
            rec_out     = bit'(i & 1);
            gold_valid  = 1'b1;
            @(negedge CK);
        end
        rec_valid  = 1'b0;
        gold_valid = 1'b0;
        check("done hold", int'(done), 1);
        check_results("done hold", 2, 1, 'h00, 1, 0);

        for (int r = 0; r < 6; r++) begin
            string tag = $sformatf("rnd%0d", r);
            set_gold(2);
            build(2, -1, -1, -1, 1'b1);
            model(mm, vld, first, dup, ps);
            do_start(tag);
            do_load(tag, 1'b1, 1'b1, -1);
            do_records(tag, 2, 1'b1, 1000);
            check_results(tag, mm, vld, first, dup, ps);
        end

        // start mid-LOAD is ignored: rec_ready still waits for all DEPTH transfers.
        set_gold(0);
        build(0, -1, -1, -1, 1'b0);
        do_start("midload");
        do_load("midload", 1'b0, 1'b0, 50);
        do_records("midload", 0, 1'b0, 1000);
        check_results("midload", 0, 0, 0, 0, 1);

        // Asynchronous reset at record 60, then a clean rerun.
        set_gold(2);
        build(0, 3, 7, -1, 1'b0);
        do_start("rstrun");
        do_load("rstrun", 1'b0, 1'b0, -1);
        do_records("rstrun", 0, 1'b0, 60);
        check("rstrun pre-reset mismatches", int'(mismatch_count), 2);
        #2 reset = 1'b1;
        #1;
        check("rstrun outputs on reset",
              int'({gold_ready, rec_ready, busy, done, pass, mismatch_count,
                    first_mismatch_vld, first_mismatch_idx, dup_err}), 0);
        @(negedge CK);
        reset = 1'b0;
        @(negedge CK);
        check("rstrun idle after reset", int'(busy), 0);
        build(0, -1, -1, -1, 1'b0);
        do_start("rerun");
        do_load("rerun", 1'b0, 1'b0, -1);
        do_records("rerun", 0, 1'b0, 1000);
        check_results("rerun", 0, 0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
